// File: rtl/mac_cfg_loader.sv
// mac_cfg_loader: assembles a framed chunk stream into a shadow word and commits it to the MAC cluster cfg bus with a one-cycle cset.
// Latency: cset and the new cfg appear in the cycle after the final-chunk accept; mac_en and ready are held low for the commit and guard cycles.
// Backpressure: ready drops during commit, guard (and readback); the sender holds its chunk until ready returns. Optional macro: MAC_CFG_READBACK_EN.
module mac_cfg_loader #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH,
    parameter int CFG_WIDTH      = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH,
    parameter int CHUNK_WIDTH    = 8,
    parameter int NUM_CHUNKS     = (CFG_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH
) (
`ifdef MAC_CFG_READBACK_EN
    input  logic                   rb_req,
    output logic                   rb_valid,
    output logic [CHUNK_WIDTH-1:0] rb_data,
`endif
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   cfg_in_valid,
    output logic                   cfg_in_ready,
    input  logic [CHUNK_WIDTH-1:0] cfg_in_data,
    input  logic                   cfg_in_last,
    output logic                   cset,
    output logic [CFG_WIDTH-1:0]   cfg,
    output logic                   mac_en,
    output logic                   busy,
    output logic                   err
);

    localparam int CNT_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int FRAME_W  = NUM_CHUNKS * CHUNK_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_GUARD  = 3'd3;
`ifdef MAC_CFG_READBACK_EN
    localparam logic [2:0] ST_RDBK   = 3'd4;
`endif

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
    logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
    logic                 err_q, err_d;

    logic                 in_frame;
    logic                 accept;
    logic                 cnt_is_last;
    logic                 rb_start;
    logic [FRAME_W-1:0]   chunk_ext;
    logic [FRAME_W-1:0]   chunk_mask;

    assign in_frame    = (state_q == ST_IDLE) || (state_q == ST_SHIFT);
    assign accept      = cfg_in_valid && cfg_in_ready;
    assign cnt_is_last = (cnt_q == CNT_LAST);

    // Incoming chunk and its lane mask, placed at the slot selected by cnt.
    assign chunk_ext  = FRAME_W'(cfg_in_data) << (cnt_q * CHUNK_WIDTH);
    assign chunk_mask = FRAME_W'({CHUNK_WIDTH{1'b1}}) << (cnt_q * CHUNK_WIDTH);

`ifdef MAC_CFG_READBACK_EN
    logic [CNT_W-1:0]   rb_cnt_q, rb_cnt_d;
    logic [FRAME_W-1:0] rb_word;

    // Readback only starts from IDLE; it wins over a chunk offered in the same cycle.
    assign rb_start = (state_q == ST_IDLE) && rb_req;
    assign rb_word  = FRAME_W'(cfg_q);
    assign rb_valid = (state_q == ST_RDBK);
    assign rb_data  = CHUNK_WIDTH'(rb_word >> (rb_cnt_q * CHUNK_WIDTH));
`else
    assign rb_start = 1'b0;
`endif

    assign cfg_in_ready = rst && in_frame && !rb_start;
    assign cset         = (state_q == ST_COMMIT);
    assign cfg          = cfg_q;
    assign mac_en       = rst && en && in_frame;
    assign busy         = (state_q != ST_IDLE);
    assign err          = err_q;

    // Next-state: chunk assembly, frame completion/commit, framing errors, commit/guard sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        err_d    = 1'b0;
`ifdef MAC_CFG_READBACK_EN
        rb_cnt_d = rb_cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_SHIFT: begin
                if (accept) begin
                    // Bits of the final chunk above CFG_WIDTH fall off in the truncation.
                    shadow_d = CFG_WIDTH'((FRAME_W'(shadow_q) & ~chunk_mask) | chunk_ext);
                    if (cnt_is_last && cfg_in_last) begin
                        cfg_d    = shadow_d;
                        shadow_d = '0;
                        cnt_d    = '0;
                        state_d  = ST_COMMIT;
                    end else if (cnt_is_last || cfg_in_last) begin
                        // Early last or missing last: drop the partial frame, keep live cfg.
                        err_d    = 1'b1;
                        shadow_d = '0;
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
`ifdef MAC_CFG_READBACK_EN
                else if (rb_start) begin
                    rb_cnt_d = '0;
                    state_d  = ST_RDBK;
                end
`endif
            end
            ST_COMMIT: state_d = ST_GUARD;
            ST_GUARD:  state_d = ST_IDLE;
`ifdef MAC_CFG_READBACK_EN
            ST_RDBK: begin
                if (rb_cnt_q == CNT_LAST) begin
                    rb_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    rb_cnt_d = rb_cnt_q + 1'b1;
                end
            end
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; a reset aborts any frame or commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            cfg_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            err_q    <= err_d;
        end
    end

`ifdef MAC_CFG_READBACK_EN
    // Readback chunk counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rb_cnt_q <= '0;
        end else begin
            rb_cnt_q <= rb_cnt_d;
        end
    end
`endif

endmodule
